imem_load_arbiter: RTL and testbench

Controller that owns the single address/write port of the byte-addressed instruction memory (32-bit big-endian words, MEM_BYTES deep, registered read, one write per cycle).
It sequences a boot-time program load from a streaming source (valid/ready) into consecutive word addresses. It then hands the port to the CPU fetch unit.
It holds the CPU until a complete load finishes and flags overflow and misaligned or out-of-range fetches.

---
 rtl/imem_load_arbiter.sv | 133 +++++++++++++
 tb/tb_imem_load_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_arbiter.sv
// Owns the instruction-memory address/write port: streams a boot image into memory, then hands the port to CPU fetch.
// Writes are combinational on handshake; fetch status (valid/fault) follows a grant by one cycle.
module imem_load_arbiter #(
    parameter int unsigned MEM_BYTES = 4000,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_valid,
    output logic        fetch_fault,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] load_count,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
    localparam logic [31:0] BASE      = 32'(BASE_ADDR);

    state_t      state_q, state_d;
    logic [31:0] wr_ptr_q, wr_ptr_d;
    logic [15:0] count_q, count_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        fvalid_q, fvalid_d;
    logic        ffault_q, ffault_d;
    logic        fetch_ok;
    logic        overflow;

    assign fetch_ok = (fetch_addr[1:0] == 2'b00) && (fetch_addr <= LAST_WORD);
    assign overflow = wr_ptr_q > LAST_WORD;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        done_d     = done_q;
        err_d      = err_q;
        fvalid_d   = 1'b0;
        ffault_d   = 1'b0;
        load_ready = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        fetch_gnt  = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (!load_start) begin
                    if (overflow) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        load_ready = 1'b1;
                        if (load_valid) begin
                            mem_write = 1'b1;
                            mem_addr  = wr_ptr_q;
                            mem_wdata = load_data;
                            wr_ptr_d  = wr_ptr_q + 32'd4;
                            count_d   = count_q + 16'd1;
                            if (load_last) begin
                                state_d = S_RUN;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            S_RUN: begin
                fetch_gnt = fetch_req;
                mem_addr  = fetch_addr;
                fvalid_d  = fetch_req & fetch_ok;
                ffault_d  = fetch_req & ~fetch_ok;
            end
            default: ;
        endcase

        // A grant issued in RUN on the same cycle as load_start still gets its status next cycle.
        if (load_start) begin
            state_d  = S_LOAD;
            wr_ptr_d = BASE;
            count_d  = 16'd0;
            done_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= BASE;
            count_q  <= 16'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fvalid_q <= 1'b0;
            ffault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            ffault_q <= ffault_d;
        end
    end

    assign cpu_hold    = (state_q != S_RUN);
    assign load_done   = done_q;
    assign load_err    = err_q;
    assign load_count  = count_q;
    assign fetch_valid = fvalid_q;
    assign fetch_fault = ffault_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench: a default-size instance backed by a big-endian memory model, plus a 16-byte instance for overflow.
module tb_imem_load_arbiter;

    logic        clk = 1'b0;
    logic        reset, load_start, load_valid, load_last, fetch_req;
    logic [31:0] load_data, fetch_addr;

    logic        load_ready, fetch_gnt, fetch_valid, fetch_fault, cpu_hold, load_done, load_err, mem_write;
    logic [15:0] load_count;
    logic [31:0] mem_addr, mem_wdata;

    logic        s_load_ready, s_fetch_gnt, s_fetch_valid, s_fetch_fault, s_cpu_hold, s_load_done, s_load_err, s_mem_write;
    logic [15:0] s_load_count;
    logic [31:0] s_mem_addr, s_mem_wdata;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [0:4095];
    logic [31:0] rdata;

    always #5 clk = ~clk;

    imem_load_arbiter dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_fault(fetch_fault), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err), .load_count(load_count),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write)
    );

    imem_load_arbiter #(.MEM_BYTES(16), .BASE_ADDR(0)) dut_s (
        .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(s_load_ready),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(s_fetch_gnt),
        .fetch_valid(s_fetch_valid), .fetch_fault(s_fetch_fault), .cpu_hold(s_cpu_hold),
        .load_done(s_load_done), .load_err(s_load_err), .load_count(s_load_count),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_write(s_mem_write)
    );

    // Byte memory, big-endian words, registered read.
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[11:0]]          <= mem_wdata[31:24];
            mem[mem_addr[11:0] + 12'd1]  <= mem_wdata[23:16];
            mem[mem_addr[11:0] + 12'd2]  <= mem_wdata[15:8];
            mem[mem_addr[11:0] + 12'd3]  <= mem_wdata[7:0];
        end
        rdata <= {mem[mem_addr[11:0]], mem[mem_addr[11:0] + 12'd1],
                  mem[mem_addr[11:0] + 12'd2], mem[mem_addr[11:0] + 12'd3]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge; inputs are driven there and outputs sampled 1ns later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    logic [31:0] ovf_words [0:4];

    initial begin
        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = 32'd0; fetch_req = 1'b0; fetch_addr = 32'd0;
        tick(); tick(); settle();

        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        chk("rst_count", {16'd0, load_count}, 32'd0);
        chk("rst_fvalid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_ffault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_write", {31'd0, mem_write}, 32'd0);

        // Basic three-word load, continuous valid.
        tick(); reset = 1'b0; load_start = 1'b1; settle();
        chk("idle_ready", {31'd0, load_ready}, 32'd0);
        chk("idle_addr", mem_addr, 32'd0);
        tick(); load_start = 1'b0; load_valid = 1'b1; load_data = 32'h11223344; settle();
        chk("l1_write", {31'd0, mem_write}, 32'd1);
        chk("l1_addr", mem_addr, 32'd0);
        chk("l1_wdata", mem_wdata, 32'h11223344);
        chk("l1_hold", {31'd0, cpu_hold}, 32'd1);
        tick(); load_data = 32'hAABBCCDD; settle();
        chk("l2_write", {31'd0, mem_write}, 32'd1);
        chk("l2_addr", mem_addr, 32'd4);
        tick(); load_data = 32'h00000013; load_last = 1'b1; settle();
        chk("l3_write", {31'd0, mem_write}, 32'd1);
        chk("l3_addr", mem_addr, 32'd8);
        chk("l3_count", {16'd0, load_count}, 32'd2);
        tick(); load_valid = 1'b0; load_last = 1'b0; settle();
        chk("run_count", {16'd0, load_count}, 32'd3);
        chk("run_done", {31'd0, load_done}, 32'd1);
        chk("run_hold", {31'd0, cpu_hold}, 32'd0);
        chk("run_ready", {31'd0, load_ready}, 32'd0);
        chk("run_write", {31'd0, mem_write}, 32'd0);

        // Good fetch at 4.
        fetch_req = 1'b1; fetch_addr = 32'd4; settle();
        chk("f4_gnt", {31'd0, fetch_gnt}, 32'd1);
        chk("f4_addr", mem_addr, 32'd4);
        tick(); fetch_req = 1'b0; settle();
        chk("f4_valid", {31'd0, fetch_valid}, 32'd1);
        chk("f4_fault", {31'd0, fetch_fault}, 32'd0);
        chk("f4_data", rdata, 32'hAABBCCDD);

        // Misaligned, out-of-range, then good fetch at 0.
        fetch_req = 1'b1; fetch_addr = 32'd2; settle();
        chk("f2_gnt", {31'd0, fetch_gnt}, 32'd1);
        tick(); fetch_addr = 32'd4000; settle();
        chk("f2_valid", {31'd0, fetch_valid}, 32'd0);
        chk("f2_fault", {31'd0, fetch_fault}, 32'd1);
        chk("f4000_gnt", {31'd0, fetch_gnt}, 32'd1);
        tick(); fetch_addr = 32'd0; settle();
        chk("f4000_valid", {31'd0, fetch_valid}, 32'd0);
        chk("f4000_fault", {31'd0, fetch_fault}, 32'd1);
        tick(); fetch_req = 1'b0; settle();
        chk("f0_valid", {31'd0, fetch_valid}, 32'd1);
        chk("f0_fault", {31'd0, fetch_fault}, 32'd0);
        chk("f0_data", rdata, 32'h11223344);
        tick(); settle();
        chk("idle_fvalid", {31'd0, fetch_valid}, 32'd0);
        chk("idle_ffault", {31'd0, fetch_fault}, 32'd0);

        // Restart from RUN with a fetch in flight, then throttled two-word load.
        load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 32'd8; settle();
        chk("rs_gnt", {31'd0, fetch_gnt}, 32'd1);
        chk("rs_hold", {31'd0, cpu_hold}, 32'd0);
        tick(); load_start = 1'b0; load_valid = 1'b1; load_data = 32'hA1A1A1A1; settle();
        chk("rs_owed_valid", {31'd0, fetch_valid}, 32'd1);
        chk("rs_load_gnt", {31'd0, fetch_gnt}, 32'd0);
        chk("rs_hold_up", {31'd0, cpu_hold}, 32'd1);
        chk("rs_done_clr", {31'd0, load_done}, 32'd0);
        chk("t1_write", {31'd0, mem_write}, 32'd1);
        chk("t1_addr", mem_addr, 32'd0);
        tick(); fetch_req = 1'b0; load_valid = 1'b0; settle();
        chk("t_gap_write", {31'd0, mem_write}, 32'd0);
        chk("t_gap_count", {16'd0, load_count}, 32'd1);
        tick(); load_valid = 1'b1; load_data = 32'hB2B2B2B2; load_last = 1'b1; settle();
        chk("t2_write", {31'd0, mem_write}, 32'd1);
        chk("t2_addr", mem_addr, 32'd4);
        tick(); load_valid = 1'b0; load_last = 1'b0; settle();
        chk("t_end_write", {31'd0, mem_write}, 32'd0);
        chk("t_end_count", {16'd0, load_count}, 32'd2);
        chk("t_end_done", {31'd0, load_done}, 32'd1);

        // Restart mid-load.
        load_start = 1'b1; tick();
        load_start = 1'b0; load_valid = 1'b1; load_data = 32'h01010101; settle();
        chk("r0_addr", mem_addr, 32'd0);
        tick(); load_data = 32'h02020202; settle();
        chk("r1_addr", mem_addr, 32'd4);
        tick(); load_start = 1'b1; load_data = 32'h03030303; settle();
        chk("r2_ready", {31'd0, load_ready}, 32'd0);
        chk("r2_write", {31'd0, mem_write}, 32'd0);
        tick(); load_start = 1'b0; load_data = 32'h04040404; settle();
        chk("r3_write", {31'd0, mem_write}, 32'd1);
        chk("r3_addr", mem_addr, 32'd0);
        chk("r3_count", {16'd0, load_count}, 32'd0);
        tick(); settle();
        chk("r4_count", {16'd0, load_count}, 32'd1);

        // Reset after two words of this load.
        tick(); reset = 1'b1; settle();
        chk("mr_count_pre", {16'd0, load_count}, 32'd2);
        tick(); reset = 1'b0; settle();
        chk("mr_hold", {31'd0, cpu_hold}, 32'd1);
        chk("mr_done", {31'd0, load_done}, 32'd0);
        chk("mr_count", {16'd0, load_count}, 32'd0);
        chk("mr_write", {31'd0, mem_write}, 32'd0);
        chk("mr_ready", {31'd0, load_ready}, 32'd0);

        // Overflow on the 16-byte instance.
        load_valid = 1'b0; load_start = 1'b1; tick();
        load_start = 1'b0; load_valid = 1'b1;
        ovf_words[0] = 32'hC0000000; ovf_words[1] = 32'hC0000001; ovf_words[2] = 32'hC0000002;
        ovf_words[3] = 32'hC0000003; ovf_words[4] = 32'hC0000004;
        for (int i = 0; i < 4; i++) begin
            load_data = ovf_words[i]; settle();
            chk($sformatf("ov%0d_write", i), {31'd0, s_mem_write}, 32'd1);
            chk($sformatf("ov%0d_addr", i), s_mem_addr, 32'(4 * i));
            chk($sformatf("ov%0d_wdata", i), s_mem_wdata, ovf_words[i]);
            tick();
        end
        load_data = ovf_words[4]; settle();
        chk("ov4_ready", {31'd0, s_load_ready}, 32'd0);
        chk("ov4_write", {31'd0, s_mem_write}, 32'd0);
        chk("ov4_big_addr", mem_addr, 32'd16);
        tick(); load_valid = 1'b0; settle();
        chk("ov_err", {31'd0, s_load_err}, 32'd1);
        chk("ov_hold", {31'd0, s_cpu_hold}, 32'd1);
        chk("ov_count", {16'd0, s_load_count}, 32'd4);
        chk("ov_ready", {31'd0, s_load_ready}, 32'd0);
        chk("ov_done", {31'd0, s_load_done}, 32'd0);
        chk("ov_big_err", {31'd0, load_err}, 32'd0);
        fetch_req = 1'b1; fetch_addr = 32'd0; settle();
        chk("ov_err_gnt", {31'd0, s_fetch_gnt}, 32'd0);
        tick(); fetch_req = 1'b0; settle();
        chk("ov_err_stay", {31'd0, s_load_err}, 32'd1);
        chk("ov_err_fvalid", {31'd0, s_fetch_valid}, 32'd0);
        chk("ov_err_ffault", {31'd0, s_fetch_fault}, 32'd0);
        chk("ov_err_count", {16'd0, s_load_count}, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
